pipe_adder_tree: RTL and testbench
==================================

PIPE_ADDER_TREE -- requirements
Module: pipe_adder_tree

Interface
REQ-001 Parameter N_WORDS, default 16: number of input words; power of two, 2..64.
REQ-002 Parameter WIDTH, default 25: bit width of each input word.
REQ-003 Parameter OUT_WIDTH, default 25: RES width; 1 <= OUT_WIDTH <= WIDTH+log2(N_WORDS).
REQ-004 Parameter SIGNED, default 0: 0 means unsigned two's-complement-free operands; 1 means signed operands.
REQ-005 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 RST  input  1  reset; asynchronous, active-high.
REQ-007 IN_VALID  input  1  WORDS carries a valid operand set this cycle.
REQ-008 WORDS  input  N_WORDS*WIDTH  packed operands; word k occupies bits [k*WIDTH +: WIDTH].
REQ-009 OUT_VALID  output  1  RES and SAT are valid this cycle.
REQ-010 RES  output  OUT_WIDTH  sum of the operand set, saturated to OUT_WIDTH.
REQ-011 SAT  output  1  RES was clipped for this result.

Function
REQ-012 LEVELS = log2(N_WORDS); the full-precision sum width is FULL_W = WIDTH + LEVELS.
REQ-013 Level L (1..LEVELS) shall add adjacent pairs from level L-1 into N_WORDS/2^L registers of width WIDTH+L, sign- or zero-extended per SIGNED; no intermediate overflow is possible.
REQ-014 One additional output stage shall saturate the FULL_W sum to OUT_WIDTH; total latency from IN_VALID sample to OUT_VALID = LEVELS+1 cycles (5 at default).
REQ-015 Valid shall propagate through a LEVELS+1 bit shift chain aligned with the data; the pipeline accepts one new set every cycle (throughput 1/cycle), with no backpressure.
REQ-016 Data registers of a stage shall load only when that stage's incoming valid is high; otherwise they hold their value.
REQ-017 Unsigned saturation: sum > 2^OUT_WIDTH-1 -> RES = all ones, SAT=1.
REQ-018 Signed saturation: sum > 2^(OUT_WIDTH-1)-1 -> RES = max positive, SAT=1; sum < -2^(OUT_WIDTH-1) -> RES = min negative, SAT=1.
REQ-019 When OUT_WIDTH = FULL_W, SAT shall be constant 0 and RES shall equal the exact sum.
REQ-020 When OUT_VALID=0, RES and SAT hold the last valid values.
REQ-021 IN_VALID gaps (bubbles) shall produce matching OUT_VALID gaps; no result is dropped, duplicated or reordered.

Reset
REQ-022 RST high shall immediately clear all valid-chain bits, so OUT_VALID=0 and RES=0 and SAT=0 while RST is high.
REQ-023 RST asserted mid-operation shall discard all in-flight sets; no OUT_VALID shall be produced for any set sampled before RST deassertion.
REQ-024 The first set sampled on the first rising edge after RST deasserts shall appear LEVELS+1 cycles later.
REQ-025 Tree data registers need not be reset; only the valid chain, RES and SAT are.

Structure
REQ-026 Shared package adder_pkg shall hold the log2 helper function and the default constants for N_WORDS, WIDTH and OUT_WIDTH.
REQ-027 Sub-module add_node (one registered two-input adder, width parameter, enable, sign-extension select) shall be instantiated by generate loops per level.
REQ-028 Saturation logic shall reside in pipe_adder_tree's output stage, not in add_node.

Verification
REQ-029 Default params, unsigned, all 16 words = 1, IN_VALID one cycle -> OUT_VALID exactly 5 cycles later, RES=16, SAT=0.
REQ-030 Default params, unsigned, all words = 2^25-1 -> RES=33554431 (0x1FFFFFF), SAT=1.
REQ-031 SIGNED=1, OUT_WIDTH=25, all words = -2^24 -> RES=-2^24 (0x1000000), SAT=1; words alternating +5/-3 -> RES=16, SAT=0.
REQ-032 IN_VALID pattern 1,1,0,1 with sets summing to 10,20,-,30 -> OUT_VALID pattern 1,1,0,1 starting 5 cycles later with RES 10,20,(hold 20),30.
REQ-033 Back-to-back valid stream, RST asserted for 1 cycle asynchronously (between edges) after 3 sets -> OUT_VALID falls immediately, no stale results; next set after release emerges at latency 5.
REQ-034 OUT_WIDTH=29, all words = 2^25-1 -> RES=536870896, SAT never asserted.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined adder tree.
// All functions are constant functions, evaluated only during elaboration.
package adder_pkg;

  localparam int DEF_N_WORDS   = 16;
  localparam int DEF_WIDTH     = 25;
  localparam int DEF_OUT_WIDTH = 25;

  // Ceiling log2; returns the exact log2 for the power-of-two word counts used here.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Bit offset of a level inside the flat tree bus.
  // Level l holds n_words>>l words, each width+l bits wide.
  function automatic int level_offset(input int n_words, input int width, input int level);
    int offset;
    offset = 0;
    for (int l = 0; l < level; l++) begin
      offset += (n_words >> l) * (width + l);
    end
    return offset;
  endfunction

endpackage

// File: rtl/add_node.sv
// One registered two-input adder.
// The result is one bit wider than the operands, so the addition cannot overflow.
module add_node #(
  parameter int IN_W   = 25,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            en,
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  output logic [IN_W:0]   sum
);

  logic [IN_W:0] a_ext;
  logic [IN_W:0] b_ext;

  assign a_ext = {(SIGNED != 0) ? a[IN_W-1] : 1'b0, a};
  assign b_ext = {(SIGNED != 0) ? b[IN_W-1] : 1'b0, b};

  // NOTE: data registers carry no reset; the valid chain alone decides whether their contents matter.
  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (en) sum <= a_ext + b_ext;
  end

endmodule

// File: rtl/pipe_adder_tree.sv
// Pipelined binary adder tree: log2(N_WORDS) adder levels plus a saturating output stage.
// Accepts one operand set per cycle and has no backpressure.
module pipe_adder_tree
  import adder_pkg::*;
#(
  parameter int N_WORDS   = DEF_N_WORDS,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int SIGNED    = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  input  logic [N_WORDS*WIDTH-1:0]   WORDS,
  output logic                       OUT_VALID,
  output logic [OUT_WIDTH-1:0]       RES,
  output logic                       SAT
);

  localparam int LEVELS  = log2(N_WORDS);
  localparam int FULL_W  = WIDTH + LEVELS;
  localparam int SUM_OFF = level_offset(N_WORDS, WIDTH, LEVELS);
  localparam int TREE_W  = SUM_OFF + FULL_W;

  // Every level lives in one flat bus, so each level can have its own word width.
  logic [TREE_W-1:0]    tree;
  logic [LEVELS:0]      vld;
  logic [LEVELS:0]      stage_en;
  logic [FULL_W-1:0]    sum;
  logic [OUT_WIDTH-1:0] res_next;
  logic                 sat_next;

  assign tree[N_WORDS*WIDTH-1:0] = WORDS;
  assign stage_en = {vld[LEVELS-1:0], IN_VALID};
  assign sum      = tree[SUM_OFF +: FULL_W];

  genvar l, k;
  for (l = 1; l <= LEVELS; l++) begin : g_level
    localparam int IN_W    = WIDTH + l - 1;
    localparam int IN_OFF  = level_offset(N_WORDS, WIDTH, l - 1);
    localparam int OUT_OFF = level_offset(N_WORDS, WIDTH, l);
    for (k = 0; k < (N_WORDS >> l); k++) begin : g_node
      add_node #(
        .IN_W   (IN_W),
        .SIGNED (SIGNED)
      ) u_node (
        .clk (CLK),
        .en  (stage_en[l-1]),
        .a   (tree[IN_OFF + (2*k)*IN_W   +: IN_W]),
        .b   (tree[IN_OFF + (2*k+1)*IN_W +: IN_W]),
        .sum (tree[OUT_OFF + k*(IN_W+1) +: IN_W+1])
      );
    end
  end

  // Valid chain: vld[l-1] qualifies tree level l, vld[LEVELS] qualifies the output stage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) vld <= '0;
    else     vld <= {vld[LEVELS-1:0], IN_VALID};
  end

  assign OUT_VALID = vld[LEVELS];

  if (OUT_WIDTH == FULL_W) begin : g_exact
    assign res_next = sum;
    assign sat_next = 1'b0;
  end else if (SIGNED != 0) begin : g_sat_signed
    localparam logic [OUT_WIDTH-1:0] MAX_POS = {OUT_WIDTH{1'b1}} >> 1;
    localparam logic [OUT_WIDTH-1:0] MIN_NEG = ~MAX_POS;
    logic [FULL_W-OUT_WIDTH:0] top;
    assign top = sum[FULL_W-1:OUT_WIDTH-1];
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
      res_next = sum[OUT_WIDTH-1:0];
      sat_next = 1'b0;
      if (!((&top) || !(|top))) begin
        sat_next = 1'b1;
        res_next = sum[FULL_W-1] ? MIN_NEG : MAX_POS;
      end
    end
  end else begin : g_sat_unsigned
    always_comb begin
      res_next = sum[OUT_WIDTH-1:0];
      sat_next = 1'b0;
      if (|sum[FULL_W-1:OUT_WIDTH]) begin
        sat_next = 1'b1;
        res_next = '1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RES <= '0;
      SAT <= 1'b0;
    end else if (stage_en[LEVELS]) begin
      RES <= res_next;
      SAT <= sat_next;
    end
  end

endmodule

// File: tb/tb_pipe_adder_tree.sv
// Scoreboard bench: three tree instances (unsigned/25, signed/25, unsigned/29) checked
// by one negedge monitor against hand-computed expectations queued at issue time.
module tb_pipe_adder_tree;

  typedef struct {
    logic [31:0] res;
    logic        sat;
    int          cyc;
  } exp_t;

  localparam logic [24:0] MAX25 = 25'h1FF_FFFF;
  localparam logic [24:0] MIN_S = 25'h100_0000;
  localparam logic [24:0] MAX_S = 25'h0FF_FFFF;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iv_a, iv_b, iv_c;
  logic [399:0] words_a, words_b, words_c;
  logic        ov_a, ov_b, ov_c;
  logic        sat_a, sat_b, sat_c;
  logic [24:0] res_a, res_b;
  logic [28:0] res_c;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb [3][$];
  logic [31:0] last_r [3];
  logic        last_s [3];
  string       nm [3] = '{"uns25", "sgn25", "uns29"};

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  pipe_adder_tree u_a (
    .CLK(CLK), .RST(RST), .IN_VALID(iv_a), .WORDS(words_a),
    .OUT_VALID(ov_a), .RES(res_a), .SAT(sat_a)
  );

  pipe_adder_tree #(.SIGNED(1)) u_b (
    .CLK(CLK), .RST(RST), .IN_VALID(iv_b), .WORDS(words_b),
    .OUT_VALID(ov_b), .RES(res_b), .SAT(sat_b)
  );

  pipe_adder_tree #(.OUT_WIDTH(29)) u_c (
    .CLK(CLK), .RST(RST), .IN_VALID(iv_c), .WORDS(words_c),
    .OUT_VALID(ov_c), .RES(res_c), .SAT(sat_c)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Word 0 = w0, word 1 = w1, words 2..15 = base.
  function automatic logic [399:0] fill(input logic [24:0] base, input logic [24:0] w0,
                                        input logic [24:0] w1);
    logic [399:0] v;
    for (int k = 0; k < 16; k++) v[k*25 +: 25] = (k == 0) ? w0 : (k == 1) ? w1 : base;
    return v;
  endfunction

  function automatic logic [399:0] ramp();
    logic [399:0] v;
    for (int k = 0; k < 16; k++) v[k*25 +: 25] = 25'(k);
    return v;
  endfunction

  function automatic logic [399:0] alt(input logic [24:0] ev, input logic [24:0] od);
    logic [399:0] v;
    for (int k = 0; k < 16; k++) v[k*25 +: 25] = k[0] ? od : ev;
    return v;
  endfunction

  task automatic issue(input int d, input logic [399:0] w, input logic [31:0] r, input logic s);
    @(posedge CLK);
    #1;
    iv_a = (d == 0);
    iv_b = (d == 1);
    iv_c = (d == 2);
    if (d == 0) words_a = w;
    if (d == 1) words_b = w;
    if (d == 2) words_c = w;
    sb[d].push_back('{res: r, sat: s, cyc: cyc + 5});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      iv_a = 1'b0;
      iv_b = 1'b0;
      iv_c = 1'b0;
    end
  endtask

  always @(negedge CLK) begin
    logic        ov [3];
    logic [31:0] r  [3];
    logic        s  [3];
    exp_t        e;
    ov[0] = ov_a;  r[0] = {7'b0, res_a};  s[0] = sat_a;
    ov[1] = ov_b;  r[1] = {7'b0, res_b};  s[1] = sat_b;
    ov[2] = ov_c;  r[2] = {3'b0, res_c};  s[2] = sat_c;
    for (int d = 0; d < 3; d++) begin
      if (RST) begin
        last_r[d] = '0;
        last_s[d] = 1'b0;
      end else if (ov[d]) begin
        if (sb[d].size() == 0) begin
          check({nm[d], " unexpected out_valid"}, 64'(ov[d]), 64'd0);
        end else begin
          e = sb[d].pop_front();
          check({nm[d], " latency"}, 64'(cyc), 64'(e.cyc));
          check({nm[d], " res"}, 64'(r[d]), 64'(e.res));
          check({nm[d], " sat"}, 64'(s[d]), 64'(e.sat));
        end
        last_r[d] = r[d];
        last_s[d] = s[d];
      end else begin
        check({nm[d], " hold res"}, 64'(r[d]), 64'(last_r[d]));
        check({nm[d], " hold sat"}, 64'(s[d]), 64'(last_s[d]));
      end
    end
  end

  initial begin
    RST = 1'b1;
    iv_a = 1'b0;  iv_b = 1'b0;  iv_c = 1'b0;
    words_a = '0; words_b = '0; words_c = '0;
    #1;
    check("reset out_valid", {61'b0, ov_a, ov_b, ov_c}, 64'd0);
    check("reset res", {res_a, res_b}, 64'd0);
    check("reset sat", {61'b0, sat_a, sat_b, sat_c}, 64'd0);
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RST = 1'b0;

    // Unsigned, 25-bit result.
    issue(0, fill(25'd1, 25'd1, 25'd1), 32'd16, 1'b0);
    idle(6);
    issue(0, fill(MAX25, MAX25, MAX25), 32'h1FF_FFFF, 1'b1);
    issue(0, ramp(), 32'd120, 1'b0);
    issue(0, fill(25'd0, MAX25, 25'd0), 32'h1FF_FFFF, 1'b0);
    issue(0, fill(25'd0, MAX25, 25'd1), 32'h1FF_FFFF, 1'b1);
    issue(0, fill(25'd0, 25'd10, 25'd0), 32'd10, 1'b0);
    issue(0, fill(25'd1, 25'd5, 25'd1), 32'd20, 1'b0);
    idle(1);
    issue(0, fill(25'd2, 25'd0, 25'd2), 32'd30, 1'b0);
    idle(8);

    // Signed, 25-bit result.
    issue(1, fill(MIN_S, MIN_S, MIN_S), 32'h100_0000, 1'b1);
    issue(1, alt(25'd5, 25'h1FF_FFFD), 32'd16, 1'b0);
    issue(1, fill(MAX_S, MAX_S, MAX_S), 32'h0FF_FFFF, 1'b1);
    issue(1, fill(25'd0, MIN_S, 25'd0), 32'h100_0000, 1'b0);
    issue(1, fill(25'd0, MAX25, 25'd0), 32'h1FF_FFFF, 1'b0);
    issue(1, fill(25'd0, MAX_S, 25'd1), 32'h0FF_FFFF, 1'b1);
    idle(8);

    // Unsigned, full-precision 29-bit result.
    issue(2, fill(MAX25, MAX25, MAX25), 32'd536870896, 1'b0);
    issue(2, fill(25'd1, 25'd1, 25'd1), 32'd16, 1'b0);
    idle(8);

    // Back-to-back stream, then an asynchronous reset between edges.
    for (int i = 0; i < 7; i++) issue(0, fill(25'd0, 25'(i + 1), 25'd0), 32'(i + 1), 1'b0);
    #2;
    check("pre-reset out_valid", 64'(ov_a), 64'd1);
    check("pre-reset res", 64'(res_a), 64'd2);
    RST  = 1'b1;
    iv_a = 1'b0;
    #1;
    check("async reset out_valid", 64'(ov_a), 64'd0);
    check("async reset res", 64'(res_a), 64'd0);
    check("async reset sat", 64'(sat_a), 64'd0);
    sb[0].delete();
    @(posedge CLK);
    #3;
    RST = 1'b0;
    iv_a = 1'b1;
    words_a = fill(25'd0, 25'd77, 25'd0);
    sb[0].push_back('{res: 32'd77, sat: 1'b0, cyc: cyc + 5});
    idle(12);

    for (int d = 0; d < 3; d++) check({nm[d], " results outstanding"}, 64'(sb[d].size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
